// File: rtl/oh_counter_gen.sv
// Configurable counter: binary, Gray-coded or Galois LFSR, with wrap/saturate limit handling.
// All outputs come from registers, so nothing combinational runs from inputs to outputs.
module oh_counter_gen #(
  parameter int             DW         = 32,
  parameter string          TYPE       = "BINARY",
  parameter string          LIMIT_MODE = "WRAP",
  parameter logic [DW-1:0]  TAPS       = {1'b1, {(DW-1){1'b0}}},
  parameter logic [DW-1:0]  SEED       = {{(DW-1){1'b0}}, 1'b1}
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          en,
  input  logic          dir,
  input  logic          load,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] limit,
  output logic [DW-1:0] count,
  output logic          zero,
  output logic          at_limit,
  output logic          wrap
);

  if (DW < 2 || DW > 64) begin : g_bad_dw
    $error("oh_counter_gen: DW=%0d outside 2..64", DW);
  end
  if (TYPE != "BINARY" && TYPE != "GRAY" && TYPE != "LFSR") begin : g_bad_type
    $error("oh_counter_gen: unsupported TYPE \"%s\"", TYPE);
  end
  if (TYPE != "LFSR" && LIMIT_MODE != "WRAP" && LIMIT_MODE != "SAT") begin : g_bad_limit
    $error("oh_counter_gen: unsupported LIMIT_MODE \"%s\"", LIMIT_MODE);
  end

  localparam bit            IS_LFSR = (TYPE == "LFSR");
  localparam bit            IS_GRAY = (TYPE == "GRAY");
  localparam bit            IS_WRAP = (LIMIT_MODE == "WRAP");
  localparam logic [DW-1:0] ONE     = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] RST_ST  = IS_LFSR ? SEED : '0;

  // st is the binary state B, or the LFSR state S; count is its encoded copy.
  logic [DW-1:0] st, st_nxt, cnt_nxt, lfsr_nxt;
  logic          wrap_nxt, at_nxt;

  assign lfsr_nxt = (st >> 1) ^ (st[0] ? TAPS : '0);

  // NOTE: every variable gets a default at the top of always_comb; a path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    st_nxt   = st;
    wrap_nxt = 1'b0;
    if (load) begin
      st_nxt = (IS_LFSR && wdata == '0) ? SEED : wdata;
    end else if (en) begin
      if (IS_LFSR) begin
        st_nxt   = lfsr_nxt;
        wrap_nxt = (lfsr_nxt == SEED);
      end else if (!dir) begin
        if (st >= limit) begin
          if (IS_WRAP) begin
            st_nxt   = '0;
            wrap_nxt = 1'b1;
          end
        end else begin
          st_nxt = st + ONE;
        end
      end else begin
        if (st == '0) begin
          if (IS_WRAP) begin
            st_nxt   = limit;
            wrap_nxt = 1'b1;
          end
        end else begin
          st_nxt = st - ONE;
        end
      end
    end
  end

  // Flags are evaluated on the next state so they line up with the new count.
  always_comb begin
    cnt_nxt = IS_GRAY ? (st_nxt ^ (st_nxt >> 1)) : st_nxt;
    if (IS_LFSR)  at_nxt = (st_nxt == SEED);
    else if (dir) at_nxt = (st_nxt == '0);
    else          at_nxt = (st_nxt >= limit);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      st       <= RST_ST;
      count    <= RST_ST;
      at_limit <= IS_LFSR;
      wrap     <= 1'b0;
    end else begin
      st       <= st_nxt;
      count    <= cnt_nxt;
      at_limit <= at_nxt;
      wrap     <= wrap_nxt;
    end
  end

  // Gray code is zero exactly when the binary state is zero.
  assign zero = (count == '0);

endmodule

// File: tb/tb_oh_counter_gen.sv
// Directed scoreboard bench for oh_counter_gen: four 4-bit instances covering
// BINARY/WRAP, BINARY/SAT, GRAY and LFSR configurations.
module tb_oh_counter_gen;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       nreset;
  logic       en    [N];
  logic       dir   [N];
  logic       load  [N];
  logic [3:0] wdata [N];
  logic [3:0] limit [N];
  logic [3:0] cnt   [N];
  logic       zero  [N];
  logic       al    [N];
  logic       wr    [N];

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int         d;
    string      tag;
    logic [3:0] c;
    logic       z;
    logic       a;   // 1'bx: not checked
    logic       w;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  oh_counter_gen #(.DW(4), .TYPE("BINARY"), .LIMIT_MODE("WRAP")) u_bin_wrap (
    .clk(clk), .nreset(nreset), .en(en[0]), .dir(dir[0]), .load(load[0]),
    .wdata(wdata[0]), .limit(limit[0]), .count(cnt[0]), .zero(zero[0]),
    .at_limit(al[0]), .wrap(wr[0]));

  oh_counter_gen #(.DW(4), .TYPE("BINARY"), .LIMIT_MODE("SAT")) u_bin_sat (
    .clk(clk), .nreset(nreset), .en(en[1]), .dir(dir[1]), .load(load[1]),
    .wdata(wdata[1]), .limit(limit[1]), .count(cnt[1]), .zero(zero[1]),
    .at_limit(al[1]), .wrap(wr[1]));

  oh_counter_gen #(.DW(4), .TYPE("GRAY"), .LIMIT_MODE("WRAP")) u_gray (
    .clk(clk), .nreset(nreset), .en(en[2]), .dir(dir[2]), .load(load[2]),
    .wdata(wdata[2]), .limit(limit[2]), .count(cnt[2]), .zero(zero[2]),
    .at_limit(al[2]), .wrap(wr[2]));

  oh_counter_gen #(.DW(4), .TYPE("LFSR"), .TAPS(4'b1100), .SEED(4'b0001)) u_lfsr (
    .clk(clk), .nreset(nreset), .en(en[3]), .dir(dir[3]), .load(load[3]),
    .wdata(wdata[3]), .limit(limit[3]), .count(cnt[3]), .zero(zero[3]),
    .at_limit(al[3]), .wrap(wr[3]));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic compare_pop();
    exp_t x;
    x = sb.pop_front();
    chk({x.tag, ".count"}, cnt[x.d], x.c);
    chk({x.tag, ".zero"}, 4'(zero[x.d]), 4'(x.z));
    if (x.a !== 1'bx) chk({x.tag, ".at_limit"}, 4'(al[x.d]), 4'(x.a));
    chk({x.tag, ".wrap"}, 4'(wr[x.d]), 4'(x.w));
  endtask

  // Drive one cycle on instance d, queue the expected result, compare after the edge.
  task automatic apply(input int d, input bit e, input bit dr, input bit ld,
                       input logic [3:0] wd, input logic [3:0] lim, input string tag,
                       input logic [3:0] ec, input logic ez, input logic ea, input logic ew);
    exp_t x;
    en[d] = e; dir[d] = dr; load[d] = ld; wdata[d] = wd; limit[d] = lim;
    x = '{d: d, tag: tag, c: ec, z: ez, a: ea, w: ew};
    sb.push_back(x);
    @(posedge clk); #1;
    en[d] = 1'b0; load[d] = 1'b0;
    compare_pop();
  endtask

  logic [3:0] lfsr_seq [15] = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
                                4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};

  initial begin
    logic [3:0] prev, b, g;
    nreset = 1'b0;
    for (int i = 0; i < N; i++) begin
      en[i] = 0; dir[i] = 0; load[i] = 0; wdata[i] = '0; limit[i] = '0;
    end
    #12;
    chk("rst_bin.count", cnt[0], 4'd0);
    chk("rst_bin.zero", 4'(zero[0]), 4'd1);
    chk("rst_bin.wrap", 4'(wr[0]), 4'd0);
    chk("rst_gray.count", cnt[2], 4'd0);
    chk("rst_lfsr.count", cnt[3], 4'b0001);
    chk("rst_lfsr.at_limit", 4'(al[3]), 4'd1);
    chk("rst_lfsr.wrap", 4'(wr[3]), 4'd0);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;

    // BINARY / WRAP
    apply(0, 0, 0, 1, 4'd8, 4'd9, "bw_load8", 4'd8, 0, 0, 0);
    apply(0, 1, 0, 0, 4'd0, 4'd9, "bw_up9",   4'd9, 0, 1, 0);
    apply(0, 1, 0, 0, 4'd0, 4'd9, "bw_wrap0", 4'd0, 1, 0, 1);
    apply(0, 1, 1, 0, 4'd0, 4'd12, "bw_dn_wrap12", 4'd12, 0, 0, 1);
    apply(0, 1, 1, 0, 4'd0, 4'd12, "bw_dn11", 4'd11, 0, 0, 0);
    apply(0, 0, 0, 1, 4'd0, 4'd0, "bw_lim0_load", 4'd0, 1, 1, 0);
    apply(0, 1, 0, 0, 4'd0, 4'd0, "bw_lim0_a", 4'd0, 1, 1, 1);
    apply(0, 1, 0, 0, 4'd0, 4'd0, "bw_lim0_b", 4'd0, 1, 1, 1);
    apply(0, 0, 0, 1, 4'd14, 4'd5, "bw_load_over", 4'd14, 0, 1, 0);
    apply(0, 1, 0, 0, 4'd0, 4'd5, "bw_over_wrap", 4'd0, 1, 0, 1);
    apply(0, 1, 0, 1, 4'd3, 4'd0, "bw_load_beats_en", 4'd3, 0, 1, 0);
    apply(0, 0, 0, 0, 4'd9, 4'd5, "bw_hold", 4'd3, 0, 0, 0);

    // BINARY / SAT
    apply(1, 0, 0, 1, 4'd9, 4'd9, "bs_load9", 4'd9, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      apply(1, 1, 0, 0, 4'd0, 4'd9, $sformatf("bs_sat%0d", i), 4'd9, 0, 1, 0);
    apply(1, 1, 1, 0, 4'd0, 4'd9, "bs_dn8", 4'd8, 0, 0, 0);
    apply(1, 0, 1, 1, 4'd0, 4'd9, "bs_load0", 4'd0, 1, 1, 0);
    apply(1, 1, 1, 0, 4'd0, 4'd9, "bs_dn_sat0", 4'd0, 1, 1, 0);

    // GRAY
    apply(2, 0, 0, 1, 4'd5, 4'd15, "gr_load5", 4'b0111, 0, 0, 0);
    apply(2, 1, 0, 0, 4'd0, 4'd15, "gr_up6", 4'b0101, 0, 0, 0);
    apply(2, 1, 0, 0, 4'd0, 4'd15, "gr_up7", 4'b0100, 0, 0, 0);
    apply(2, 0, 0, 1, 4'd0, 4'd15, "gr_load0", 4'b0000, 1, 0, 0);
    prev = cnt[2];
    for (int i = 1; i <= 16; i++) begin
      b = 4'(i);
      g = b ^ (b >> 1);
      apply(2, 1, 0, 0, 4'd0, 4'd15, $sformatf("gr_sweep%0d", i), g, (b == 0),
            (b == 4'd15), (i == 16));
      chk($sformatf("gr_sweep%0d.onebit", i), 4'($countones(prev ^ cnt[2])), 4'd1);
      prev = cnt[2];
    end

    // LFSR: dir and limit toggled to show they are ignored
    for (int i = 0; i < 15; i++)
      apply(3, 1, i[0], 0, 4'd0, 4'(i), $sformatf("lf_step%0d", i + 1), lfsr_seq[i],
            0, (i == 14), (i == 14));
    apply(3, 0, 0, 1, 4'd0, 4'd0, "lf_load0", 4'b0001, 0, 1, 0);
    apply(3, 0, 0, 1, 4'd7, 4'd0, "lf_load7", 4'b0111, 0, 0, 0);
    apply(3, 1, 0, 0, 4'd0, 4'd0, "lf_from7", 4'b1111, 0, 0, 0);
    apply(3, 0, 0, 1, 4'd1, 4'd0, "lf_load_seed", 4'b0001, 0, 1, 0);

    // Asynchronous reset between edges, abandoning a live wrap pulse
    apply(0, 1, 0, 0, 4'd0, 4'd0, "pre_rst_wrap", 4'd0, 1, 1, 1);
    en[0] = 1'b1; en[3] = 1'b1;
    #1 nreset = 1'b0;
    #1;
    chk("async_rst_bw.count", cnt[0], 4'd0);
    chk("async_rst_bw.wrap", 4'(wr[0]), 4'd0);
    chk("async_rst_bs.count", cnt[1], 4'd0);
    chk("async_rst_gr.count", cnt[2], 4'd0);
    chk("async_rst_lf.count", cnt[3], 4'b0001);
    en[0] = 1'b0; en[3] = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;
    apply(3, 1, 0, 0, 4'd0, 4'd0, "post_rst_lf", 4'hC, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
